// File: rtl/jt89_wrq.sv
// -----------------------------------------------------------------------------
// jt89_wrq : CPU-side write queue in front of the jt89 PSG.
//
// Single-cycle CPU byte writes are buffered in a small FIFO and replayed to the
// PSG as clean wr_n strobes. Each PSG write goes through IDLE -> SETUP ->
// STROBE -> HOLD. This guarantees that wr_n is high for at least one cycle
// before every low phase, so the PSG's falling-edge detector sees every write.
//
// Optional feature macro: JT89_WRQ_GG_STEREO_EN
//   defined   : cpu_sel=1 writes (Game Gear stereo port) are queued in order
//               with PSG writes. When popped they load psg_mux. No strobe is
//               issued for them.
//   undefined : cpu_sel=1 writes are ignored and psg_mux is tied to 8'hFF.
//
// Parameters
//   DEPTH  FIFO entries (power of two, 2..16)
//   PULSE  cycles psg_wr_n is held low per write (>=1)
//   GAP    cycles psg_wr_n is held high after the low phase (>=1)
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   cpu_we/sel/din       CPU write strobe, port select (0 PSG, 1 stereo), data
//   full, busy, ovf      FIFO full, queue/FSM active, sticky overflow
//   ovf_clr              clears ovf (a new overflow in the same cycle wins)
//   psg_ready            the FSM only pops while this is high
//   psg_din, psg_wr_n    registered data and write strobe to the PSG
//   psg_mux              registered stereo mux value to the PSG
// -----------------------------------------------------------------------------
module jt89_wrq #(
    parameter int DEPTH = 4,
    parameter int PULSE = 2,
    parameter int GAP   = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cpu_we,
    input  logic       cpu_sel,
    input  logic [7:0] cpu_din,
    output logic       full,
    output logic       busy,
    output logic       ovf,
    input  logic       ovf_clr,
    input  logic       psg_ready,
    output logic [7:0] psg_din,
    output logic       psg_wr_n,
    output logic [7:0] psg_mux
);

    localparam int PW   = $clog2(DEPTH);
    localparam int CNTW = $clog2(DEPTH + 1);
    localparam int TMAX = (PULSE > GAP) ? PULSE : GAP;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [CNTW-1:0] COUNT_FULL = CNTW'(DEPTH);
    localparam logic [TW-1:0]   PULSE_LAST = TW'(PULSE - 1);
    localparam logic [TW-1:0]   GAP_LAST   = TW'(GAP - 1);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    // ---------------------------------------------------------------- FIFO
    logic [8:0]      mem [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0] count_q, count_d;
    logic            ovf_q, ovf_d;

    logic            accept;
    logic            push;
    logic            pop;
    logic            ovf_set;
    logic [8:0]      head;
    logic            head_sel;
    logic [7:0]      head_data;

    // --------------------------------------------------------------- FSM
    state_t          state_q, state_d;
    logic [TW-1:0]   tmr_q, tmr_d;
    logic [7:0]      psg_din_q, psg_din_d;
    logic            psg_wr_n_q, psg_wr_n_d;

`ifdef JT89_WRQ_GG_STEREO_EN
    logic [7:0]      psg_mux_q, psg_mux_d;
    assign accept = cpu_we;
`else
    // Stereo-port writes are discarded entirely: no push and no overflow.
    assign accept = cpu_we & ~cpu_sel;
`endif

    assign head      = mem[rd_ptr_q];
    assign head_sel  = head[8];
    assign head_data = head[7:0];

    assign full = (count_q == COUNT_FULL);
    assign busy = (count_q != '0) || (state_q != IDLE);
    assign ovf  = ovf_q;

    assign pop = (state_q == IDLE) && (count_q != '0) && psg_ready;
    // A pop in the same cycle frees a slot, so a push while full still fits.
    assign push    = accept && (!full || pop);
    assign ovf_set = accept && full && !pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNTW'(1);
            2'b01:   count_d = count_q - CNTW'(1);
            default: count_d = count_q;
        endcase
        // A new overflow takes priority over a simultaneous clear.
        if (ovf_set) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    // Storage carries no reset: emptiness is tracked by the pointers and the count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= {cpu_sel, cpu_din};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // ----------------------------------------------- FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            tmr_q   <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
        end
    end

    // ---------------------------------------------- FSM: next-state logic
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        case (state_q)
            IDLE: begin
                // Stereo entries are consumed here and keep the FSM in IDLE.
                if (pop && !head_sel) begin
                    state_d = SETUP;
                end
            end
            SETUP: begin
                state_d = STROBE;
                tmr_d   = '0;
            end
            STROBE: begin
                if (tmr_q == PULSE_LAST) begin
                    state_d = HOLD;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            HOLD: begin
                if (tmr_q == GAP_LAST) begin
                    state_d = IDLE;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                tmr_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------- FSM: output logic
    // The outputs are registered from the next state so that they change
    // together with the state and never glitch.
    always_comb begin
        psg_wr_n_d = (state_d != STROBE);
        psg_din_d  = psg_din_q;
        if (pop && !head_sel) begin
            psg_din_d = head_data;
        end
`ifdef JT89_WRQ_GG_STEREO_EN
        psg_mux_d = psg_mux_q;
        if (pop && head_sel) begin
            psg_mux_d = head_data;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psg_din_q  <= 8'h00;
            psg_wr_n_q <= 1'b1;
        end else begin
            psg_din_q  <= psg_din_d;
            psg_wr_n_q <= psg_wr_n_d;
        end
    end

`ifdef JT89_WRQ_GG_STEREO_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psg_mux_q <= 8'hFF;
        end else begin
            psg_mux_q <= psg_mux_d;
        end
    end
    assign psg_mux = psg_mux_q;
`else
    assign psg_mux = 8'hFF;
`endif

    assign psg_din  = psg_din_q;
    assign psg_wr_n = psg_wr_n_q;

endmodule

// File: tb/tb_jt89_wrq.sv
// -----------------------------------------------------------------------------
// tb_jt89_wrq : self-checking bench for jt89_wrq.
// The reference model keeps the queue as a SystemVerilog queue. It tracks
// the write engine as a pair of edge numbers: when the strobe starts and
// when the engine is free again.
// -----------------------------------------------------------------------------
module tb_jt89_wrq;

    localparam int DEPTH    = 4;
    localparam int PULSE    = 2;
    localparam int GAP      = 2;
    localparam int PERIOD_C = 2 + PULSE + GAP;
`ifdef JT89_WRQ_GG_STEREO_EN
    localparam bit STEREO = 1'b1;
`else
    localparam bit STEREO = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cpu_we, cpu_sel, ovf_clr, psg_ready;
    logic [7:0] cpu_din;
    logic       full, busy, ovf, psg_wr_n;
    logic [7:0] psg_din, psg_mux;

    int checks = 0;
    int errors = 0;

    jt89_wrq #(.DEPTH(DEPTH), .PULSE(PULSE), .GAP(GAP)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cpu_we    (cpu_we),
        .cpu_sel   (cpu_sel),
        .cpu_din   (cpu_din),
        .full      (full),
        .busy      (busy),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr),
        .psg_ready (psg_ready),
        .psg_din   (psg_din),
        .psg_wr_n  (psg_wr_n),
        .psg_mux   (psg_mux)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------ model
    int         cyc = 0;
    logic [8:0] mq[$];
    int         low_start;
    int         free_at;
    bit         m_ovf;
    logic [7:0] m_din, m_mux;
    logic [7:0] exp_str[$];
    logic [7:0] obs_str[$];
    int         obs_cyc[$];

    // Record every falling edge of the strobe together with the data it carries.
    always @(negedge psg_wr_n) begin
        if (rst_n === 1'b1) begin
            obs_str.push_back(psg_din);
            obs_cyc.push_back(cyc);
        end
    end

    task automatic model_reset();
        mq.delete();
        exp_str.delete();
        obs_str.delete();
        obs_cyc.delete();
        low_start = -1000;
        free_at   = 0;
        m_ovf     = 1'b0;
        m_din     = 8'h00;
        m_mux     = 8'hFF;
    endtask

    function automatic bit exp_wr_n();
        return !(cyc >= low_start && cyc < low_start + PULSE);
    endfunction

    function automatic bit exp_busy();
        return (mq.size() != 0) || (cyc + 1 < free_at);
    endfunction

    // Advance one clock edge and apply the queue rules to the inputs seen there.
    task automatic tick();
        logic [8:0] e;
        bit pop, full_m, acc, ovf_set;
        @(posedge clk);
        cyc++;
        if (rst_n !== 1'b1) begin
            model_reset();
        end else begin
            pop     = (cyc >= free_at) && (mq.size() != 0) && (psg_ready === 1'b1);
            full_m  = (mq.size() == DEPTH);
            acc     = cpu_we && (STEREO || !cpu_sel);
            ovf_set = 1'b0;
            if (pop) begin
                e = mq.pop_front();
                if (!e[8]) begin
                    m_din     = e[7:0];
                    low_start = cyc + 1;
                    free_at   = cyc + PERIOD_C;
                    exp_str.push_back(e[7:0]);
                end else begin
                    m_mux   = e[7:0];
                    free_at = cyc + 1;
                end
            end
            if (acc) begin
                if (!full_m || pop) mq.push_back({cpu_sel, cpu_din});
                else                ovf_set = 1'b1;
            end
            if (ovf_set)      m_ovf = 1'b1;
            else if (ovf_clr) m_ovf = 1'b0;
        end
        #1;
    endtask

    task automatic set_idle();
        cpu_we  = 1'b0;
        cpu_sel = 1'b0;
        cpu_din = 8'h00;
        ovf_clr = 1'b0;
    endtask

    task automatic push(input logic sel, input logic [7:0] d);
        cpu_we  = 1'b1;
        cpu_sel = sel;
        cpu_din = d;
        tick();
        set_idle();
    endtask

    task automatic drain();
        int n = 0;
        while ((busy === 1'b1 || mq.size() != 0) && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL drain_timeout got busy=%b after %0d cycles, required idle", busy, n);
        end
    endtask

    // ------------------------------------------------------------ tests
    task automatic test_reset();
        set_idle();
        psg_ready = 1'b1;
        rst_n = 1'b0;
        tick();
        tick();
        checks += 6;
        if (psg_wr_n !== 1'b1) begin errors++; $display("FAIL reset_wr_n got=%b exp=1", psg_wr_n); end
        if (psg_din !== 8'h00) begin errors++; $display("FAIL reset_din got=%h exp=00", psg_din); end
        if (psg_mux !== 8'hFF) begin errors++; $display("FAIL reset_mux got=%h exp=ff", psg_mux); end
        if (ovf !== 1'b0)      begin errors++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
        if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        if (full !== 1'b0)     begin errors++; $display("FAIL reset_full got=%b exp=0", full); end
        rst_n = 1'b1;
        tick();
        $display("reset: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_single();
        int e0, low_cnt, first_low;
        psg_ready = 1'b1;
        obs_str.delete(); exp_str.delete(); obs_cyc.delete();
        push(1'b0, 8'h9F);
        e0 = cyc;
        low_cnt = 0;
        first_low = -1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (psg_wr_n !== exp_wr_n()) begin
                errors++;
                $display("FAIL single_wr_n cyc=%0d got=%b exp=%b", cyc - e0, psg_wr_n, exp_wr_n());
            end
            if (psg_wr_n === 1'b0) begin
                low_cnt++;
                if (first_low < 0) first_low = cyc - e0;
            end
            if (cyc - e0 >= 1 && cyc - e0 <= 1 + PULSE + GAP) begin
                checks++;
                if (psg_din !== 8'h9F) begin
                    errors++;
                    $display("FAIL single_din cyc=%0d got=%h exp=9f", cyc - e0, psg_din);
                end
            end
        end
        checks += 2;
        if (low_cnt != PULSE) begin errors++; $display("FAIL single_pulse_len got=%0d exp=%0d", low_cnt, PULSE); end
        if (first_low != 2)   begin errors++; $display("FAIL single_latency got=%0d exp=2", first_low); end
        $display("single: data=9f low_cycles=%0d first_low_edge=%0d", low_cnt, first_low);
    endtask

    task automatic test_overflow();
        psg_ready = 1'b0;
        obs_str.delete(); exp_str.delete(); obs_cyc.delete();
        for (int i = 0; i < 5; i++) push(1'b0, 8'h80 + 8'(i));
        checks += 2;
        if (ovf !== 1'b1)  begin errors++; $display("FAIL ovf_set got=%b exp=1", ovf); end
        if (full !== 1'b1) begin errors++; $display("FAIL ovf_full got=%b exp=1", full); end
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        checks++;
        if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_clr got=%b exp=0", ovf); end
        psg_ready = 1'b1;
        drain();
        checks++;
        if (obs_str.size() != 4) begin
            errors++;
            $display("FAIL ovf_count got=%0d exp=4", obs_str.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (obs_str[i] !== 8'h80 + 8'(i)) begin
                    errors++;
                    $display("FAIL ovf_order idx=%0d got=%h exp=%h", i, obs_str[i], 8'h80 + 8'(i));
                end
            end
        end
        $display("overflow: strobes=%0d ovf_after_clr=%b", obs_str.size(), ovf);
    endtask

    task automatic test_push_pop_full();
        psg_ready = 1'b0;
        obs_str.delete(); exp_str.delete(); obs_cyc.delete();
        for (int i = 0; i < 4; i++) push(1'b0, 8'hA0 + 8'(i));
        psg_ready = 1'b1;
        push(1'b0, 8'hA4);
        checks += 2;
        if (ovf !== 1'b0)  begin errors++; $display("FAIL pushpop_ovf got=%b exp=0", ovf); end
        if (full !== 1'b1) begin errors++; $display("FAIL pushpop_full got=%b exp=1", full); end
        drain();
        checks++;
        if (obs_str.size() != 5) begin
            errors++;
            $display("FAIL pushpop_count got=%0d exp=5", obs_str.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (obs_str[i] !== 8'hA0 + 8'(i)) begin
                    errors++;
                    $display("FAIL pushpop_order idx=%0d got=%h exp=%h", i, obs_str[i], 8'hA0 + 8'(i));
                end
            end
        end
        $display("push_pop_full: strobes=%0d", obs_str.size());
    endtask

    task automatic test_ready_gate();
        psg_ready = 1'b0;
        obs_str.delete(); exp_str.delete(); obs_cyc.delete();
        push(1'b0, 8'hC1);
        push(1'b0, 8'hC2);
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (psg_wr_n !== 1'b1) begin errors++; $display("FAIL gate_hold cyc=%0d got=%b exp=1", i, psg_wr_n); end
        end
        psg_ready = 1'b1;
        drain();
        checks++;
        if (obs_str.size() != 2) begin
            errors++;
            $display("FAIL gate_count got=%0d exp=2", obs_str.size());
        end else begin
            checks += 3;
            if (obs_cyc[1] - obs_cyc[0] != PERIOD_C) begin
                errors++;
                $display("FAIL gate_spacing got=%0d exp=%0d", obs_cyc[1] - obs_cyc[0], PERIOD_C);
            end
            if (obs_str[0] !== 8'hC1) begin errors++; $display("FAIL gate_data0 got=%h exp=c1", obs_str[0]); end
            if (obs_str[1] !== 8'hC2) begin errors++; $display("FAIL gate_data1 got=%h exp=c2", obs_str[1]); end
        end
        $display("ready_gate: strobes=%0d", obs_str.size());
    endtask

    task automatic test_stereo();
        logic [7:0] exp_mux2;
        bit seen1 = 0, seen2 = 0;
        exp_mux2 = STEREO ? 8'hF0 : 8'hFF;
        psg_ready = 1'b1;
        obs_str.delete(); exp_str.delete(); obs_cyc.delete();
        push(1'b0, 8'h90);
        push(1'b1, 8'hF0);
        push(1'b0, 8'hB0);
        for (int i = 0; i < 20; i++) begin
            tick();
            checks += 2;
            if (psg_mux !== m_mux) begin errors++; $display("FAIL stereo_mux cyc=%0d got=%h exp=%h", i, psg_mux, m_mux); end
            if (psg_wr_n !== exp_wr_n()) begin errors++; $display("FAIL stereo_wr_n cyc=%0d got=%b exp=%b", i, psg_wr_n, exp_wr_n()); end
            if (obs_str.size() >= 1 && !seen1) begin
                seen1 = 1;
                checks++;
                if (psg_mux !== 8'hFF) begin errors++; $display("FAIL stereo_mux_first got=%h exp=ff", psg_mux); end
            end
            if (obs_str.size() >= 2 && !seen2) begin
                seen2 = 1;
                checks++;
                if (psg_mux !== exp_mux2) begin errors++; $display("FAIL stereo_mux_second got=%h exp=%h", psg_mux, exp_mux2); end
            end
        end
        checks += 2;
        if (obs_str.size() != 2) begin
            errors++;
            $display("FAIL stereo_strobes got=%0d exp=2", obs_str.size());
        end
        if (psg_mux !== exp_mux2) begin errors++; $display("FAIL stereo_mux_final got=%h exp=%h", psg_mux, exp_mux2); end
        $display("stereo: strobes=%0d mux=%h", obs_str.size(), psg_mux);
    endtask

    task automatic test_reset_mid();
        int n = 0;
        psg_ready = 1'b1;
        push(1'b0, 8'hD1);
        push(1'b0, 8'hD2);
        push(1'b0, 8'hD3);
        while (psg_wr_n !== 1'b0 && n < 10) begin
            tick();
            n++;
        end
        checks++;
        if (psg_wr_n !== 1'b0) begin errors++; $display("FAIL midrst_no_strobe got=%b exp=0", psg_wr_n); end
        #2;
        rst_n = 1'b0;
        #1;
        checks += 4;
        if (psg_wr_n !== 1'b1) begin errors++; $display("FAIL midrst_wr_n got=%b exp=1", psg_wr_n); end
        if (busy !== 1'b0)     begin errors++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        if (psg_mux !== 8'hFF) begin errors++; $display("FAIL midrst_mux got=%h exp=ff", psg_mux); end
        if (full !== 1'b0)     begin errors++; $display("FAIL midrst_full got=%b exp=0", full); end
        model_reset();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            checks++;
            if (psg_wr_n !== 1'b1) begin errors++; $display("FAIL midrst_after cyc=%0d got=%b exp=1", i, psg_wr_n); end
        end
        checks += 2;
        if (obs_str.size() != 0) begin errors++; $display("FAIL midrst_lost got=%0d strobes exp=0", obs_str.size()); end
        if (busy !== 1'b0)       begin errors++; $display("FAIL midrst_idle got=%b exp=0", busy); end
        $display("reset_mid: strobes_after=%0d busy=%b", obs_str.size(), busy);
    endtask

    task automatic test_random();
        obs_str.delete(); exp_str.delete(); obs_cyc.delete();
        for (int i = 0; i < 800; i++) begin
            cpu_we    = ($urandom_range(0, 1) == 1);
            cpu_sel   = ($urandom_range(0, 9) < 3);
            cpu_din   = 8'($urandom);
            ovf_clr   = ($urandom_range(0, 19) == 0);
            psg_ready = ($urandom_range(0, 3) != 0);
            tick();
            checks += 6;
            if (psg_wr_n !== exp_wr_n()) begin errors++; $display("FAIL rnd_wr_n i=%0d got=%b exp=%b", i, psg_wr_n, exp_wr_n()); end
            if (psg_din !== m_din)       begin errors++; $display("FAIL rnd_din i=%0d got=%h exp=%h", i, psg_din, m_din); end
            if (psg_mux !== m_mux)       begin errors++; $display("FAIL rnd_mux i=%0d got=%h exp=%h", i, psg_mux, m_mux); end
            if (ovf !== m_ovf)           begin errors++; $display("FAIL rnd_ovf i=%0d got=%b exp=%b", i, ovf, m_ovf); end
            if (full !== (mq.size() == DEPTH)) begin errors++; $display("FAIL rnd_full i=%0d got=%b exp=%b", i, full, mq.size() == DEPTH); end
            if (busy !== exp_busy())     begin errors++; $display("FAIL rnd_busy i=%0d got=%b exp=%b", i, busy, exp_busy()); end
        end
        set_idle();
        psg_ready = 1'b1;
        drain();
        checks++;
        if (obs_str.size() != exp_str.size()) begin
            errors++;
            $display("FAIL rnd_strobe_count got=%0d exp=%0d", obs_str.size(), exp_str.size());
        end else begin
            foreach (exp_str[i]) begin
                checks++;
                if (obs_str[i] !== exp_str[i]) begin
                    errors++;
                    $display("FAIL rnd_strobe_data idx=%0d got=%h exp=%h", i, obs_str[i], exp_str[i]);
                end
            end
        end
        $display("random: strobes=%0d", obs_str.size());
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_overflow();
        test_push_pop_full();
        test_ready_gate();
        test_stereo();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
